// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, CSR layout and timing helper for the PS/2 blocks
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAITIDLE = 3'd5
  } ps2_state_e;

  // CSR bit positions
  localparam int unsigned CSR_ERR = 15;
  localparam int unsigned CSR_NAK = 14;
  localparam int unsigned CSR_OVR = 13;
  localparam int unsigned CSR_RDY = 7;
  localparam int unsigned CSR_IE  = 6;

  // Number of consecutive agreeing samples before a line level is accepted
  localparam int unsigned FILT_LEN = 8;

  // Microseconds to clock cycles at the given clock frequency
  function automatic int unsigned us2cyc(input int unsigned clkfreq, input int unsigned us);
    return (clkfreq / 32'd1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_linefilt.sv
// rtl/ps2_linefilt.sv - PS/2 pin synchroniser and stable-level filter with falling-edge pulse
module ps2_linefilt
  import ps2_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CW = $clog2(FILT_LEN);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_fall;
  logic          w_diff;
  logic          w_take;

  assign w_diff  = r_s2 ^ r_level;
  assign w_take  = w_diff && (r_cnt == CW'(FILT_LEN - 1));
  assign o_level = r_level;
  assign o_fall  = r_fall;

  // Two-flop synchroniser; idle PS/2 lines sit high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after FILT_LEN consecutive samples disagree with the current one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= w_take && r_level;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_take) begin
        r_cnt   <= '0;
        r_level <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - Wishbone-attached PS/2 host-to-device transmitter with interrupt
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLKFREQ      = 50000000,
  parameter int unsigned INHIBIT_US   = 100,
  parameter int unsigned START_TMO_US = 15000,
  parameter int unsigned FRAME_TMO_US = 2000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        irq,
  input  logic        iack,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic        busy
);

  localparam int unsigned INH_CYC   = us2cyc(CLKFREQ, INHIBIT_US);
  localparam int unsigned START_CYC = us2cyc(CLKFREQ, START_TMO_US);
  localparam int unsigned FRAME_CYC = us2cyc(CLKFREQ, FRAME_TMO_US);
  localparam int unsigned INH_W     = $clog2(INH_CYC + 1);
  localparam int unsigned START_W   = $clog2(START_CYC + 1);
  localparam int unsigned FRAME_W   = $clog2(FRAME_CYC + 1);

  localparam logic [INH_W-1:0]   INH_LAST   = INH_W'(INH_CYC - 1);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_CYC - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYC - 1);

  logic w_clk_lvl;
  logic w_clk_fall;
  logic w_data_lvl;
  logic w_data_fall;

  logic w_req;
  logic w_csr_wr;
  logic w_data_wr;
  logic w_accept;
  logic w_ie_rise;
  logic w_stmo;
  logic w_ftmo;
  logic [15:0] w_csr;
  logic w_unused;

  ps2_state_e         r_state;
  logic               r_clk_oe;
  logic               r_data_oe;
  logic               r_rdy;
  logic               r_err;
  logic               r_nak;
  logic               r_ovr;
  logic               r_ie;
  logic               r_taken;
  logic               r_ack;
  logic [15:0]        r_dat;
  logic [7:0]         r_shift;
  logic               r_par;
  logic [3:0]         r_bitn;
  logic [INH_W-1:0]   r_icnt;
  logic [START_W-1:0] r_stmr;
  logic [FRAME_W-1:0] r_ftmr;

  ps2_linefilt u_clk_filt (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_i),
    .i_pin   (ps2_clk_i),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_linefilt u_data_filt (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_i),
    .i_pin   (ps2_data_i),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall)
  );

  // A new request is one not already being acknowledged; RDY is used as registered
  assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_csr_wr  = w_req & wb_we_i & ~wb_adr_i[1];
  assign w_data_wr = w_req & wb_we_i & wb_adr_i[1];
  assign w_accept  = w_data_wr & wb_sel_i[0] & r_rdy;
  assign w_ie_rise = w_csr_wr & wb_sel_i[0] & wb_dat_i[6] & ~r_ie;
  assign w_stmo    = (r_stmr >= START_LAST);
  assign w_ftmo    = (r_ftmr >= FRAME_LAST);
  assign w_unused  = ^{wb_adr_i[15:2], wb_adr_i[0], wb_dat_i[15:8], wb_sel_i[1], w_data_fall};

  assign wb_ack_o    = r_ack;
  assign wb_dat_o    = r_dat;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign busy        = (r_state != ST_IDLE);
  assign irq         = r_ie & r_rdy & ~r_taken;

  // CSR read image
  always_comb begin
    w_csr          = '0;
    w_csr[CSR_ERR] = r_err;
    w_csr[CSR_NAK] = r_nak;
    w_csr[CSR_OVR] = r_ovr;
    w_csr[CSR_RDY] = r_rdy;
    w_csr[CSR_IE]  = r_ie;
  end

  // Bus side: ack/read data, IE, overrun flag and interrupt-taken latch
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_ie    <= 1'b0;
      r_ovr   <= 1'b0;
      r_taken <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= '0;
      if (w_req && !wb_we_i && !wb_adr_i[1]) begin
        r_dat <= w_csr;
      end
      if (w_csr_wr) begin
        r_ovr <= 1'b0;
        if (wb_sel_i[0]) begin
          r_ie <= wb_dat_i[6];
        end
      end
      if (w_data_wr && !r_rdy) begin
        r_ovr <= 1'b1;
      end
      if (w_accept || w_ie_rise) begin
        r_taken <= 1'b0;
      end else if (iack) begin
        r_taken <= 1'b1;
      end
    end
  end

  // Frame sequencer: inhibit, start bit, shift on device falling edges, ack, recover
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_rdy     <= 1'b1;
      r_err     <= 1'b0;
      r_nak     <= 1'b0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bitn    <= '0;
      r_icnt    <= '0;
      r_stmr    <= '0;
      r_ftmr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (w_accept) begin
            r_shift <= wb_dat_i[7:0];
            r_par   <= ~^wb_dat_i[7:0];
            r_err   <= 1'b0;
            r_nak   <= 1'b0;
            r_rdy   <= 1'b0;
            r_icnt  <= '0;
            r_state <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          r_clk_oe <= 1'b1;
          r_icnt   <= r_icnt + 1'b1;
          if (r_icnt == INH_LAST) begin
            r_data_oe <= 1'b1;
            r_state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_clk_oe <= 1'b0;
          r_stmr   <= '0;
          r_bitn   <= '0;
          r_state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_stmr <= r_stmr + 1'b1;
          r_ftmr <= r_ftmr + 1'b1;
          if (w_clk_fall) begin
            r_bitn <= r_bitn + 1'b1;
            if (r_bitn == 4'd0) begin
              r_ftmr <= '0;
            end
            if (r_bitn < 4'd8) begin
              r_data_oe <= ~r_shift[r_bitn[2:0]];
            end else if (r_bitn == 4'd8) begin
              r_data_oe <= ~r_par;
            end else begin
              r_data_oe <= 1'b0;
              r_state   <= ST_ACK;
            end
          end else if ((r_bitn == 4'd0) ? w_stmo : w_ftmo) begin
            r_err     <= 1'b1;
            r_rdy     <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_ACK: begin
          r_ftmr <= r_ftmr + 1'b1;
          if (w_clk_fall) begin
            r_nak   <= w_data_lvl;
            r_state <= ST_WAITIDLE;
          end else if (w_ftmo) begin
            r_err     <= 1'b1;
            r_rdy     <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_WAITIDLE: begin
          if (w_clk_lvl && w_data_lvl) begin
            r_rdy   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_rdy     <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;

  localparam int unsigned CLKF    = 1000000;
  localparam int unsigned INH_US  = 100;
  localparam int unsigned STMO_US = 3000;
  localparam int unsigned FTMO_US = 2000;
  localparam int INH  = (CLKF / 1000000) * INH_US;
  localparam int STMO = (CLKF / 1000000) * STMO_US;
  localparam logic [15:0] A_CSR  = 16'h0000;
  localparam logic [15:0] A_DATA = 16'h0002;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [1:0]  wb_sel_i = 2'b00;
  logic        wb_ack_o;
  logic        irq;
  logic        iack = 1'b0;
  logic        ps2_clk_i;
  logic        ps2_data_i;
  logic        ps2_clk_oe;
  logic        ps2_data_oe;
  logic        busy;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // reference-model state
  logic m_ie = 1'b0;
  logic m_ovr = 1'b0;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  // open-drain wired-AND of host and device
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(
    .CLKFREQ      (CLKF),
    .INHIBIT_US   (INH_US),
    .START_TMO_US (STMO_US),
    .FRAME_TMO_US (FTMO_US)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_sel_i    (wb_sel_i),
    .wb_ack_o    (wb_ack_o),
    .irq         (irq),
    .iack        (iack),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_csr(input logic err, input logic nak);
    return (err ? 16'h8000 : 16'h0) | (nak ? 16'h4000 : 16'h0) |
           (m_ovr ? 16'h2000 : 16'h0) | 16'h0080 | (m_ie ? 16'h0040 : 16'h0);
  endfunction

  // Frame as seen on the data line before each of the 11 device falling edges
  function automatic logic [10:0] exp_bits(input logic [7:0] d);
    logic [10:0] b;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    b[9]  = ($countones(d) % 2 == 0);
    b[10] = 1'b1;
    return b;
  endfunction

  task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [1:0] sel,
                         input logic [15:0] dat, output logic [15:0] rd);
    int t;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!wb_ack_o && t < 8);
    check("wb_ack_latency", t, 1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  // Device: wait for host release, then clock npulse bits at 80-cycle period
  task automatic dev_frame(input int npulse, input logic ack, output logic [10:0] bits);
    int t;
    bits = '0;
    t = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("dev_release_seen", (t < 1000), 1);
    for (int i = 0; i < npulse; i++) begin
      repeat (20) @(posedge clk);
      #1 bits[i] = ps2_data_i;
      if (i == 10 && ack) dev_data_low = 1'b1;
      repeat (20) @(posedge clk);
      dev_clk_low = 1'b1;
      repeat (40) @(posedge clk);
      dev_clk_low = 1'b0;
    end
    if (npulse == 11) begin
      repeat (20) @(posedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic finish_frame(input string name, input logic [7:0] d, input logic ack);
    logic [10:0] bits;
    logic [15:0] rd;
    dev_frame(11, ack, bits);
    check({name, "_bits"}, bits, exp_bits(d));
    repeat (30) @(posedge clk);
    wb_xfer(1'b0, A_CSR, 2'b11, 16'h0, rd);
    check({name, "_csr"}, rd, exp_csr(1'b0, ~ack));
    check({name, "_irq"}, irq, m_ie);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [10:0] bits;
    logic [7:0]  d;
    logic        ack;
    int t, hi, first_d;

    tbl[0]  = '{1'b0, A_CSR,  2'b11, 16'h0000, 16'h0080, 1'b0};
    tbl[1]  = '{1'b0, A_DATA, 2'b11, 16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, A_CSR,  2'b10, 16'hFFFF, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, A_CSR,  2'b11, 16'h0000, 16'h0080, 1'b0};
    tbl[4]  = '{1'b1, A_CSR,  2'b01, 16'h0040, 16'h0000, 1'b1};
    tbl[5]  = '{1'b0, A_CSR,  2'b11, 16'h0000, 16'h00C0, 1'b1};
    tbl[6]  = '{1'b1, A_DATA, 2'b10, 16'h00AA, 16'h0000, 1'b1};
    tbl[7]  = '{1'b0, A_CSR,  2'b11, 16'h0000, 16'h00C0, 1'b1};
    tbl[8]  = '{1'b1, A_CSR,  2'b11, 16'h0000, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, A_CSR,  2'b11, 16'h0000, 16'h0080, 1'b0};
    tbl[10] = '{1'b1, A_CSR,  2'b11, 16'hFFFF, 16'h0000, 1'b1};
    tbl[11] = '{1'b0, A_CSR,  2'b11, 16'h0000, 16'h00C0, 1'b1};

    // reset state
    #12;
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat_o", wb_dat_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // register table
    for (int i = 0; i < 12; i++) begin
      wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd);
      check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_irq", i), irq, tbl[i].exp_irq);
      check($sformatf("tbl%0d_busy", i), busy, 0);
    end
    m_ie = 1'b1;

    // basic frame 0xED with inhibit timing
    wb_xfer(1'b1, A_DATA, 2'b01, 16'h00ED, rd);
    check("inh_ack_cycle_clk_oe", ps2_clk_oe, 0);
    check("inh_busy", busy, 1);
    check("inh_irq_low", irq, 0);
    @(posedge clk); #1;
    check("inh_latency", ps2_clk_oe, 1);
    hi = 0; first_d = -1;
    while (ps2_clk_oe && hi < 10000) begin
      if (ps2_data_oe && first_d < 0) first_d = hi;
      hi++;
      @(posedge clk); #1;
    end
    check("inh_len", hi, INH);
    check("inh_start_bit_cycle", first_d, INH - 1);
    check("release_data_oe", ps2_data_oe, 1);
    dev_frame(11, 1'b1, bits);
    check("basic_bits", bits, 11'h7DA);
    repeat (30) @(posedge clk);
    wb_xfer(1'b0, A_CSR, 2'b11, 16'h0, rd);
    check("basic_csr", rd, 16'h00C0);
    check("basic_irq", irq, 1);

    // explicit NAK
    wb_xfer(1'b1, A_DATA, 2'b01, 16'h00A5, rd);
    finish_frame("nak", 8'hA5, 1'b0);

    // randomized frames against the model
    for (int k = 0; k < 4; k++) begin
      d   = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) != 0);
      wb_xfer(1'b1, A_DATA, 2'b01, {8'h00, d}, rd);
      finish_frame($sformatf("rnd%0d", k), d, ack);
    end

    // no device: start timeout
    wb_xfer(1'b1, A_DATA, 2'b01, 16'h0055, rd);
    t = 0;
    while (!ps2_clk_oe && t < 100) begin @(posedge clk); #1; t++; end
    while (ps2_clk_oe && t < 1000) begin @(posedge clk); #1; t++; end
    check("tmo_release_seen", (t < 1000), 1);
    repeat (STMO - 1) @(posedge clk);
    #1 check("tmo_busy_before", busy, 1);
    @(posedge clk); #1;
    check("tmo_busy_after", busy, 0);
    check("tmo_clk_oe", ps2_clk_oe, 0);
    check("tmo_data_oe", ps2_data_oe, 0);
    wb_xfer(1'b0, A_CSR, 2'b11, 16'h0, rd);
    check("tmo_csr", rd, exp_csr(1'b1, 1'b0));
    check("tmo_irq", irq, 1);

    // overrun, iack, rearm
    wb_xfer(1'b1, A_DATA, 2'b01, 16'h003C, rd);
    wb_xfer(1'b1, A_DATA, 2'b01, 16'h005A, rd);
    m_ovr = 1'b1;
    finish_frame("ovr", 8'h3C, 1'b1);
    repeat (200) @(posedge clk);
    #1 check("ovr_single_frame", busy, 0);
    @(posedge clk); #1;
    iack = 1'b1;
    @(posedge clk); #1;
    iack = 1'b0;
    check("iack_irq", irq, 0);
    wb_xfer(1'b1, A_CSR, 2'b01, 16'h0040, rd);
    m_ovr = 1'b0;
    check("iack_irq_held", irq, 0);
    wb_xfer(1'b0, A_CSR, 2'b11, 16'h0, rd);
    check("ovr_cleared_csr", rd, 16'h00C0);
    d = 8'($urandom_range(0, 255));
    wb_xfer(1'b1, A_DATA, 2'b01, {8'h00, d}, rd);
    finish_frame("rearm", d, 1'b1);

    // reset mid-frame at bit 4
    wb_xfer(1'b1, A_DATA, 2'b01, 16'h0000, rd);
    dev_frame(5, 1'b1, bits);
    check("mid_clk_oe", ps2_clk_oe, 0);
    check("mid_data_oe", ps2_data_oe, 1);
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_oe", ps2_clk_oe, 0);
    check("async_data_oe", ps2_data_oe, 0);
    check("async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ie = 1'b0;
    wb_xfer(1'b0, A_CSR, 2'b11, 16'h0, rd);
    check("post_rst_csr", rd, 16'h0080);
    check("post_rst_irq", irq, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
